// File: rtl/oam_dma_ram_pkg.sv
// oam_pkg: shared constants and types for the OAM + OAM DMA block.
//   dmaState_t   : DMA engine state encoding (IDLE / REQ / WRITE)
//   OAM_DEPTH    : number of sprite attribute bytes (40 sprites x 4)
//   OAM_BASE     : CPU bus address of OAM entry 0
//   DMA_REG      : CPU bus address of the DMA start/page register
//   OAM_OPEN_BUS : value seen by the CPU when OAM is not readable
package oam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } dmaState_t;

    localparam int          OAM_DEPTH    = 160;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] DMA_REG      = 16'hFF46;
    localparam logic [7:0]  OAM_OPEN_BUS = 8'hFF;

endpackage

// File: rtl/oam_dma_ram_dpram.sv
// oam_dpram: dual-port RAM with registered reads, block-RAM friendly.
//   clk              : clock
//   aAddr/aWe/aWrData: port A address, write strobe, write data
//   aRdData          : port A read data, one cycle after aAddr
//   bAddr/bRdData    : port B read-only address and read data
// Both ports return the old contents on a read-during-write.
// Writes to addresses >= DEPTH are discarded; reads there are undefined
// and must be masked by the user.
module oam_dpram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 160,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic              aWe,
    input  logic [DATA_W-1:0] aWrData,
    output logic [DATA_W-1:0] aRdData,
    input  logic [ADDR_W-1:0] bAddr,
    output logic [DATA_W-1:0] bRdData
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (aWe && ({1'b0, aAddr} < DEPTH_V))
            mem[aAddr] <= aWrData;
        aRdData <= mem[aAddr];
    end

    always_ff @(posedge clk) begin
        bRdData <= mem[bAddr];
    end

endmodule

// File: rtl/oam_dma_ram.sv
// oam_dma_ram: object attribute memory with integrated OAM DMA engine.
//   clk, rst_n                     : clock, async active-low reset
//   cpu_addr/cpu_wr_en/cpu_wr_data : CPU port (write)
//   cpu_rd_data                    : CPU read data, 1-cycle latency
//   ppu_addr/ppu_rd_data           : PPU read-only port, 1-cycle latency
//   ppu_lock                       : PPU in mode 2/3
//   dma_start/dma_page             : start pulse and source page
//   dma_busy/dma_done              : transfer in progress / finished pulse
//   mem_addr/mem_rd_req            : source read request (held until valid)
//   mem_rd_data/mem_rd_valid       : source read response
// Optional build macro OAM_DMA_RAM_PPU_LOCK_EN: when defined, ppu_lock=1
// also blocks CPU access; otherwise ppu_lock is ignored.
module oam_dma_ram
    import oam_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               DEPTH    = OAM_DEPTH,
    parameter int               ADDR_W   = 8,
    parameter logic [DATA_W-1:0] OPEN_BUS = OAM_OPEN_BUS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr_en,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic [DATA_W-1:0] ppu_rd_data,
    input  logic              ppu_lock,
    input  logic              dma_start,
    input  logic [7:0]        dma_page,
    output logic              dma_busy,
    output logic              dma_done,
    output logic [15:0]       mem_addr,
    output logic              mem_rd_req,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid
);

    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dmaState_t         state, stateNext;
    logic [7:0]        dmaPage, pageNext;
    logic [ADDR_W-1:0] dmaIdx, idxNext;
    logic [DATA_W-1:0] capData, capNext;
    logic              doneNext;
    logic              dmaWe;

    // ---------------- DMA engine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dmaPage  <= '0;
            dmaIdx   <= '0;
            capData  <= '0;
            dma_done <= 1'b0;
        end else begin
            state    <= stateNext;
            dmaPage  <= pageNext;
            dmaIdx   <= idxNext;
            capData  <= capNext;
            dma_done <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        pageNext  = dmaPage;
        idxNext   = dmaIdx;
        capNext   = capData;
        doneNext  = 1'b0;
        dmaWe     = 1'b0;
        case (state)
            IDLE: ;
            REQ: begin
                if (mem_rd_valid) begin
                    capNext   = mem_rd_data;
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                // The byte is committed even if a restart arrives this cycle.
                dmaWe = 1'b1;
                if (dmaIdx == LAST_IDX) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end else begin
                    idxNext   = dmaIdx + ADDR_W'(1);
                    stateNext = REQ;
                end
            end
            default: stateNext = IDLE;
        endcase
        // A start pulse always (re)starts from byte 0 and swallows any done.
        if (dma_start) begin
            pageNext  = dma_page;
            idxNext   = '0;
            stateNext = REQ;
            doneNext  = 1'b0;
        end
    end

    assign dma_busy   = (state != IDLE);
    assign mem_rd_req = (state == REQ);
    assign mem_addr   = {dmaPage, 8'(dmaIdx)};

    // ---------------- CPU gating ----------------
    logic cpuBlocked;
`ifdef OAM_DMA_RAM_PPU_LOCK_EN
    assign cpuBlocked = dma_busy | ppu_lock;
`else
    logic unusedLock;
    assign unusedLock = ppu_lock;
    assign cpuBlocked = dma_busy;
`endif

    logic cpuInRange, ppuInRange;
    assign cpuInRange = ({1'b0, cpu_addr} < DEPTH_V);
    assign ppuInRange = ({1'b0, ppu_addr} < DEPTH_V);

    // Port A belongs to the DMA engine for the whole transfer.
    logic [ADDR_W-1:0] aAddr;
    logic              aWe;
    logic [DATA_W-1:0] aWrData, aRdData, bRdData;

    assign aAddr   = dma_busy ? dmaIdx  : cpu_addr;
    assign aWe     = dma_busy ? dmaWe   : (cpu_wr_en & cpuInRange & ~cpuBlocked);
    assign aWrData = dma_busy ? capData : cpu_wr_data;

    oam_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uRam (
        .clk     (clk),
        .aAddr   (aAddr),
        .aWe     (aWe),
        .aWrData (aWrData),
        .aRdData (aRdData),
        .bAddr   (ppu_addr),
        .bRdData (bRdData)
    );

    // The RAM output registers carry no reset, so read validity is tracked
    // in resettable flags aligned with the RAM read latency.
    logic cpuRdOk, ppuRdOk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpuRdOk <= 1'b0;
            ppuRdOk <= 1'b0;
        end else begin
            cpuRdOk <= cpuInRange & ~cpuBlocked;
            ppuRdOk <= ppuInRange;
        end
    end

    assign cpu_rd_data = cpuRdOk ? aRdData : OPEN_BUS;
    assign ppu_rd_data = ppuRdOk ? bRdData : '0;

endmodule

// File: doc/oam_dma_ram.md
Name: oam_dma_ram

Overview:
- Parametrised successor to the sprite attribute RAM: a dual-port object attribute memory (OAM) with an integrated OAM DMA engine.
- Port A serves the CPU. Port B is a read-only PPU port.
- The DMA engine copies one page (DEPTH bytes) from system memory into OAM over a request/valid handshake, and blocks CPU access while it runs.
- Sits between the CPU bus decoder (FE00–FE9F, FF46) and the PPU sprite fetcher.

Parameters:
- DATA_W, 8, data width of each entry.
- DEPTH, 160, number of entries. Must be ≤ 2^ADDR_W and ≤ 256.
- ADDR_W, 8, width of the OAM address.
- OPEN_BUS, 8'hFF, value returned for blocked or out-of-range CPU reads.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  CPU OAM address.
- cpu_wr_en  in  1  CPU write strobe.
- cpu_wr_data  in  DATA_W  CPU write data.
- cpu_rd_data  out  DATA_W  CPU read data, registered.
- ppu_addr  in  ADDR_W  PPU OAM address.
- ppu_rd_data  out  DATA_W  PPU read data, registered.
- ppu_lock  in  1  PPU in mode 2/3. Used only with the optional feature.
- dma_start  in  1  one-cycle pulse: write to FF46.
- dma_page  in  8  source page (high byte of source address).
- dma_busy  out  1  high while a transfer is in progress.
- dma_done  out  1  one-cycle pulse after the last byte is written.
- mem_addr  out  16  DMA source address.
- mem_rd_req  out  1  DMA read request.
- mem_rd_data  in  DATA_W  source data.
- mem_rd_valid  in  1  source data valid; completes the request.

Behaviour:
- Reset (async, rst_n=0):
  - cpu_rd_data=OPEN_BUS, ppu_rd_data=0.
  - dma_busy=0, dma_done=0, mem_rd_req=0, mem_addr=0.
  - FSM=IDLE, index=0.
  - RAM contents are not reset.
- Reads: registered, 1-cycle latency. Address sampled at edge N; data valid after edge N+1.
  - Read-during-write on the same port or the other port returns the old data.
- CPU access:
  - cpu_addr ≥ DEPTH: reads return OPEN_BUS; writes are ignored.
  - While dma_busy=1: reads return OPEN_BUS; writes are dropped.
- PPU reads are never blocked. ppu_addr ≥ DEPTH returns 0.
- FSM states: IDLE, REQ, WRITE.
  - IDLE: on dma_start → latch dma_page, index=0, dma_busy=1, go to REQ.
  - REQ: mem_rd_req=1 and mem_addr={page, index}. Both are held stable until mem_rd_valid. On mem_rd_valid → capture data, go to WRITE.
  - WRITE: RAM[index] <= captured data, mem_rd_req=0.
    - If index==DEPTH-1 → go to IDLE, dma_busy=0, dma_done=1 for one cycle.
    - Otherwise index++ and go to REQ.
- Minimum throughput: 2 cycles per byte with zero-wait memory, i.e. 320 cycles for DEPTH=160.
- dma_start while busy: restart. Latch the new page, index=0, go to REQ next cycle. Already-copied bytes remain. No dma_done is issued for the aborted transfer.
- dma_start in the same cycle as the final WRITE: the final write completes, dma_done is suppressed, and the new transfer starts.
- mem_rd_valid outside REQ is ignored.
- A DMA write and a CPU write never coincide, because the CPU is blocked while DMA runs.
- rst_n asserted mid-transfer: immediate return to IDLE. Partial OAM contents are kept.

Optional Feature:
- Macro: OAM_DMA_RAM_PPU_LOCK_EN.
- Defined: while ppu_lock=1 (and independent of DMA), CPU reads return OPEN_BUS and CPU writes are dropped.
- Not defined: ppu_lock is ignored and CPU access is gated by dma_busy only. The port stays present in both builds.

Decomposition:
- Shared package oam_pkg:
  - FSM state encoding (IDLE/REQ/WRITE).
  - OAM_DEPTH=160 and OAM_BASE=16'hFE00.
  - DMA_REG=16'hFF46.
  - OPEN_BUS constant.
- Natural sub-module: oam_dpram. A plain parametrised true-dual-port RAM with registered reads, maps to block RAM. Port A is muxed between the CPU and the DMA engine; port B is the PPU.

Test Plan:
- Reset, then CPU writes 8'h5A to addr 3 → cpu_rd_data=8'h5A one cycle after the read address is presented; ppu_addr=3 also returns 8'h5A.
- CPU write to addr 160 with data 8'h11, then read addr 160 → 8'hFF. Addr 0 is unchanged.
- dma_start with dma_page=8'hC1, source returns data=low byte with zero wait → mem_addr steps C100..C19F, RAM[i]=i, dma_done pulses once at cycle 320, dma_busy falls in the same cycle.
- During the transfer, CPU write 8'h77 to addr 5 and CPU read addr 5 → write dropped, read returns 8'hFF, RAM[5]=8'h05 after the transfer.
- mem_rd_valid delayed 3 cycles per byte → mem_addr and mem_rd_req are held stable; total time 5×160 cycles; data is correct.
- dma_start with page 8'hC2 at index 50, then rst_n low at index 20 of the new transfer → no dma_done; dma_busy=0 immediately; RAM[0..19] come from C2xx and RAM[20..49] from C1xx.
